// File: rtl/tick_ctrl_pkg.sv
// Shared types and constants for the CPU tick / clock-enable controller.
// Contents: tick_state_t FSM encoding, default divider width, tick counter width.
package tick_ctrl_pkg;

  localparam int unsigned TICK_DIV_WIDTH_DEFAULT = 16;
  localparam int unsigned TICK_CNT_WIDTH         = 32;

  typedef enum logic [1:0] {
    TS_IDLE = 2'b00,
    TS_RUN  = 2'b01,
    TS_STEP = 2'b10,
    TS_HALT = 2'b11
  } tick_state_t;

endpackage

// File: rtl/step_sync_edge.sv
// Two-flop synchroniser for an asynchronous button level plus a rising-edge
// detect on the synchronised value.
// Ports:
//   Clock      - system clock (rising edge)
//   Reset      - synchronous, active-high; clears all flops to 0
//   async_in   - asynchronous level input
//   edge_pulse - one-cycle pulse, high the cycle after the second sync flop rises
module step_sync_edge (
  input  logic Clock,
  input  logic Reset,
  input  logic async_in,
  output logic edge_pulse
);

  // [0] metastability flop, [1] synchronised level, [2] previous synchronised level
  logic [2:0] sync_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
    end
  end

  assign edge_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tick_run_controller.sv
// Generates the Tick and ClockEnable qualifiers for the CPU register stages
// under run, single-step and halt control, with a run-time tick divisor.
// Optional feature: define TICK_COUNTER_EN to add the 32-bit tick_count output.
// Ports:
//   Clock, Reset - system clock, synchronous active-high reset
//   run_req      - level, request free-running ticks
//   step_req     - asynchronous button level, each rising edge requests one tick
//   halt_in      - level, forces HALT (except while in STEP)
//   div_val      - tick every max(div_val,1) cycles while running
//   Tick         - registered one-cycle pulse per CPU cycle
//   ClockEnable  - registered, 1 in RUN and STEP
//   state        - registered FSM state
//   halted       - registered, 1 in HALT
//   tick_count   - (TICK_COUNTER_EN only) number of Tick cycles since reset
module tick_run_controller
  import tick_ctrl_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = TICK_DIV_WIDTH_DEFAULT
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      run_req,
  input  logic                      step_req,
  input  logic                      halt_in,
  input  logic [DIV_WIDTH-1:0]      div_val,
  output logic                      Tick,
  output logic                      ClockEnable,
  output logic [1:0]                state,
  output logic                      halted
`ifdef TICK_COUNTER_EN
  ,output logic [TICK_CNT_WIDTH-1:0] tick_count
`endif
);

  localparam logic [1:0] ST_IDLE = 2'(TS_IDLE);
  localparam logic [1:0] ST_RUN  = 2'(TS_RUN);
  localparam logic [1:0] ST_STEP = 2'(TS_STEP);
  localparam logic [1:0] ST_HALT = 2'(TS_HALT);

  logic                 step_edge;
  logic [1:0]           state_d;
  logic                 tick_d;
  logic                 ce_d;
  logic                 halted_d;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_lat;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic [DIV_WIDTH-1:0] lat_d;
  logic [DIV_WIDTH-1:0] div_eff;

  step_sync_edge u_step_sync (
    .Clock      (Clock),
    .Reset      (Reset),
    .async_in   (step_req),
    .edge_pulse (step_edge)
  );

  // Divisor 0 behaves like 1
  assign div_eff = (div_val == '0) ? DIV_WIDTH'(1) : div_val;

  // State and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      Tick        <= 1'b0;
      ClockEnable <= 1'b0;
      halted      <= 1'b0;
      div_cnt     <= '0;
      div_lat     <= DIV_WIDTH'(1);
    end else begin
      state       <= state_d;
      Tick        <= tick_d;
      ClockEnable <= ce_d;
      halted      <= halted_d;
      div_cnt     <= cnt_d;
      div_lat     <= lat_d;
    end
  end

  // Next-state, divider and registered-output logic
  always_comb begin
    state_d  = state;
    cnt_d    = '0;
    lat_d    = div_lat;
    tick_d   = 1'b0;
    ce_d     = 1'b0;
    halted_d = 1'b0;

    if (halt_in && (state != ST_STEP)) begin
      state_d = ST_HALT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (step_edge)    state_d = ST_STEP;
          else if (run_req) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!run_req) state_d = ST_IDLE;
        end
        ST_STEP: state_d = ST_IDLE;
        ST_HALT: begin
          // halt_in is already 0 here; run_req must drop to rearm
          if (step_edge)     state_d = ST_STEP;
          else if (!run_req) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Divisor is latched on RUN entry and at each wrap only
    if (state_d == ST_RUN) begin
      if ((state != ST_RUN) || (div_cnt == div_lat - DIV_WIDTH'(1))) begin
        cnt_d = '0;
        lat_d = div_eff;
      end else begin
        cnt_d = div_cnt + DIV_WIDTH'(1);
      end
    end

    // Tick is registered, so it is decided from the values entering the next cycle
    tick_d   = (state_d == ST_STEP) ||
               ((state_d == ST_RUN) && (cnt_d == lat_d - DIV_WIDTH'(1)));
    ce_d     = (state_d == ST_RUN) || (state_d == ST_STEP);
    halted_d = (state_d == ST_HALT);
  end

`ifdef TICK_COUNTER_EN
  // Counts cycles in which Tick is high; wraps naturally at 32 bits
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tick_count <= '0;
    end else if (Tick) begin
      tick_count <= tick_count + TICK_CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tick_run_controller.sv
// Self-checking bench for tick_run_controller: a vector table applied one
// cycle per entry, followed by hand-written step/halt sequences.
module tb_tick_run_controller;
  import tick_ctrl_pkg::*;

  localparam int unsigned DW = 16;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          run_req;
  logic          step_req;
  logic          halt_in;
  logic [DW-1:0] div_val;
  logic          Tick;
  logic          ClockEnable;
  logic [1:0]    state;
  logic          halted;
`ifdef TICK_COUNTER_EN
  logic [TICK_CNT_WIDTH-1:0] tick_count;
`endif

  int checks = 0;
  int errors = 0;

  tick_run_controller #(.DIV_WIDTH(DW)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .run_req     (run_req),
    .step_req    (step_req),
    .halt_in     (halt_in),
    .div_val     (div_val),
    .Tick        (Tick),
    .ClockEnable (ClockEnable),
    .state       (state),
    .halted      (halted)
`ifdef TICK_COUNTER_EN
    ,.tick_count (tick_count)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic          rst;
    logic          run;
    logic          hlt;
    logic [DW-1:0] div;
    logic [1:0]    e_state;
    logic          e_tick;
    logic          e_ce;
    logic          e_halted;
  } vec_t;

  vec_t vecs[$];

  localparam logic [1:0] S_I = 2'b00;
  localparam logic [1:0] S_R = 2'b01;
  localparam logic [1:0] S_S = 2'b10;
  localparam logic [1:0] S_H = 2'b11;

  task automatic add(input logic rst, input logic run, input logic hlt, input int div,
                     input logic [1:0] st, input logic tk, input logic ce, input logic hl);
    vec_t v;
    v.rst = rst; v.run = run; v.hlt = hlt; v.div = DW'(div);
    v.e_state = st; v.e_tick = tk; v.e_ce = ce; v.e_halted = hl;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [1:0] st, input logic tk,
                         input logic ce, input logic hl);
    chk({nm, ".state"}, int'(state), int'(st));
    chk({nm, ".Tick"}, int'(Tick), int'(tk));
    chk({nm, ".ClockEnable"}, int'(ClockEnable), int'(ce));
    chk({nm, ".halted"}, int'(halted), int'(hl));
  endtask

  initial begin
    int ticks;
    logic prev_tick;
    longint exp_cnt;

    Reset = 1'b1; run_req = 1'b0; step_req = 1'b0; halt_in = 1'b0; div_val = '0;

    // rst run hlt div   state tick ce halted
    add(1, 0, 0, 0, S_I, 0, 0, 0);
    // div=4: ticks in RUN cycles 4, 8, 12
    for (int k = 1; k <= 12; k++) add(0, 1, 0, 4, S_R, (k % 4) == 0, 1, 0);
    add(0, 0, 0, 4, S_I, 0, 0, 0);
    // div 0 then 1: every cycle
    add(0, 1, 0, 0, S_R, 1, 1, 0);
    add(0, 1, 0, 0, S_R, 1, 1, 0);
    add(0, 1, 0, 1, S_R, 1, 1, 0);
    add(0, 1, 0, 1, S_R, 1, 1, 0);
    // div=3 period, then change to 5 mid-period
    add(0, 1, 0, 3, S_R, 0, 1, 0);
    add(0, 1, 0, 3, S_R, 0, 1, 0);
    add(0, 1, 0, 3, S_R, 1, 1, 0);
    add(0, 1, 0, 3, S_R, 0, 1, 0);
    add(0, 1, 0, 5, S_R, 0, 1, 0);
    add(0, 1, 0, 5, S_R, 1, 1, 0);
    add(0, 1, 0, 5, S_R, 0, 1, 0);
    add(0, 1, 0, 5, S_R, 0, 1, 0);
    add(0, 1, 0, 5, S_R, 0, 1, 0);
    add(0, 1, 0, 5, S_R, 0, 1, 0);
    add(0, 1, 0, 5, S_R, 1, 1, 0);
    // div=3, halt on the edge that would raise Tick
    add(0, 1, 0, 3, S_R, 0, 1, 0);
    add(0, 1, 0, 3, S_R, 0, 1, 0);
    add(0, 1, 1, 3, S_H, 0, 0, 1);
    add(0, 1, 0, 3, S_H, 0, 0, 1);
    add(0, 0, 0, 3, S_I, 0, 0, 0);
    // reset on the edge that would raise Tick
    add(0, 1, 0, 2, S_R, 0, 1, 0);
    add(0, 1, 0, 2, S_R, 1, 1, 0);
    add(0, 1, 0, 2, S_R, 0, 1, 0);
    add(1, 1, 0, 2, S_I, 0, 0, 0);
    add(0, 0, 0, 2, S_I, 0, 0, 0);

    exp_cnt = 0;
    prev_tick = 1'b0;
    foreach (vecs[i]) begin
      Reset = vecs[i].rst; run_req = vecs[i].run; halt_in = vecs[i].hlt; div_val = vecs[i].div;
      cyc();
      chk_out($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_tick,
              vecs[i].e_ce, vecs[i].e_halted);
      exp_cnt = vecs[i].rst ? 0 : exp_cnt + longint'(prev_tick);
      prev_tick = vecs[i].e_tick;
`ifdef TICK_COUNTER_EN
      chk($sformatf("vec%0d.tick_count", i), int'(tick_count), int'(exp_cnt));
`endif
    end

    // Step from IDLE with the button held 20 cycles: one tick at E+2
    step_req = 1'b1;
    ticks = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      ticks += int'(Tick);
      if (c == 1) chk_out("step_e1", S_I, 0, 0, 0);
      if (c == 2) chk_out("step_e2", S_S, 1, 1, 0);
      if (c == 3) chk_out("step_e3", S_I, 0, 0, 0);
    end
    chk("step_held_ticks", ticks, 1);
    chk_out("step_held_end", S_I, 0, 0, 0);

    // Release, then halt and step past it with run_req high
    step_req = 1'b0;
    repeat (4) cyc();
    halt_in = 1'b1;
    cyc();
    chk_out("halt_enter", S_H, 0, 0, 1);
    halt_in = 1'b0;
    run_req = 1'b1;
    cyc();
    chk_out("halt_hold", S_H, 0, 0, 1);
    step_req = 1'b1;
    cyc();
    cyc();
    chk_out("hstep_e1", S_H, 0, 0, 1);
    cyc();
    chk_out("hstep_e2", S_S, 1, 1, 0);
    cyc();
    chk_out("hstep_e3", S_I, 0, 0, 0);
    cyc();
    chk_out("hstep_e4", S_R, 0, 1, 0);

    // Step edges are ignored while running (div=1 ticks every cycle)
    step_req = 1'b0;
    div_val = DW'(1);
    repeat (4) cyc();
    step_req = 1'b1;
    ticks = 0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      ticks += int'(Tick);
      chk($sformatf("run_step_ign%0d.state", c), int'(state), int'(S_R));
    end
    chk("run_step_ign_ticks", ticks, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
